cfg_chain_loader: RTL and testbench

- Drives the fabric's serial configuration chain, a series of DFFRQ/DFFR cells clocked from CK.
- Takes configuration bytes over a valid/ready stream and shifts them bit-serially into the chain head.
- At the same time, captures the bits leaving the chain tail, so the previous configuration is read back as bytes.
- Sits between the host interface (SPI/GPIO front end) and the configuration chain.

---
 rtl/cfg_chain_loader.sv | 135 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain loader: shifts host bytes into the chain head
// LSB first while assembling the bits leaving the chain tail into read-back bytes.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       chain_d,
    output logic       chain_en,
    input  logic       chain_q,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_tx_sr;
    logic [7:0]       r_rx_sr;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_total;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_done;
    logic             w_last_bit;
    logic             w_byte_end;
    logic [7:0]       w_rx_byte;

    assign w_last_bit = (r_total == LAST_CNT);
    assign w_byte_end = (r_bit_cnt == 3'd7);
    // The tail bit on the wire this cycle completes the byte being captured.
    assign w_rx_byte  = r_rx_sr | ({7'd0, chain_q} << r_bit_cnt);

    // State register.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WAIT;
                else       w_next = S_IDLE;
            end
            S_WAIT: begin
                if (in_valid) w_next = S_SHIFT;
                else          w_next = S_WAIT;
            end
            S_SHIFT: begin
                if (w_last_bit)      w_next = S_DONE;
                else if (w_byte_end) w_next = S_WAIT;
                else                 w_next = S_SHIFT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shift registers, counters and registered read-back / done outputs.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_tx_sr     <= 8'd0;
            r_rx_sr     <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_total     <= '0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) r_total <= '0;
                    else       r_total <= r_total;
                end
                S_WAIT: begin
                    if (in_valid) begin
                        r_tx_sr   <= in_data;
                        r_bit_cnt <= 3'd0;
                        r_rx_sr   <= 8'd0;
                    end else begin
                        r_tx_sr   <= r_tx_sr;
                    end
                end
                S_SHIFT: begin
                    r_rx_sr   <= w_rx_byte;
                    r_tx_sr   <= {1'b0, r_tx_sr[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_total   <= r_total + CNT_ONE;
                    if (w_last_bit || w_byte_end) begin
                        r_out_data  <= w_rx_byte;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_out_data  <= r_out_data;
                    end
                end
                default: begin
                    r_total <= r_total;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_WAIT);
    assign chain_en  = (r_state == S_SHIFT);
    assign chain_d   = (r_state == S_SHIFT) & r_tx_sr[0];
    assign busy      = (r_state == S_WAIT) | (r_state == S_SHIFT);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three instances (16, 12 and 1 flop chains) each
// driving a behavioural chain; results checked against expectations from the rules.
module tb_cfg_chain_loader;

    localparam int LENS [3] = '{16, 12, 1};

    logic       CK;
    logic       RST;
    logic [2:0] start;
    logic [7:0] in_data [3];
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [7:0] out_data [3];
    logic [2:0] out_valid;
    logic [2:0] chain_d;
    logic [2:0] chain_en;
    logic [2:0] chain_q;
    logic [2:0] busy;
    logic [2:0] done;

    logic [63:0] chain   [3];
    logic [63:0] pre_val [3];
    logic [2:0]  pre_req;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int shifts [3];
    int nout [3];
    int ndone [3];
    int nhs [3];
    int last_ov [3];
    int done_cyc [3];
    logic [7:0] outb [3][8];
    logic [7:0] tb_bytes [8];

    cfg_chain_loader #(.CHAIN_LEN(16), .CNT_W(16)) u_l16 (
        .CK(CK), .RST(RST), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .chain_d(chain_d[0]), .chain_en(chain_en[0]), .chain_q(chain_q[0]),
        .busy(busy[0]), .done(done[0]));

    cfg_chain_loader #(.CHAIN_LEN(12), .CNT_W(16)) u_l12 (
        .CK(CK), .RST(RST), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .chain_d(chain_d[1]), .chain_en(chain_en[1]), .chain_q(chain_q[1]),
        .busy(busy[1]), .done(done[1]));

    cfg_chain_loader #(.CHAIN_LEN(1), .CNT_W(16)) u_l1 (
        .CK(CK), .RST(RST), .start(start[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .chain_d(chain_d[2]), .chain_en(chain_en[2]), .chain_q(chain_q[2]),
        .busy(busy[2]), .done(done[2]));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    assign chain_q[0] = chain[0][0];
    assign chain_q[1] = chain[1][0];
    assign chain_q[2] = chain[2][0];

    // Physical chain: new bit enters at the head (bit LEN-1), bit 0 is the tail.
    always @(posedge CK) begin
        for (int i = 0; i < 3; i++) begin
            if (pre_req[i])
                chain[i] <= pre_val[i];
            else if (chain_en[i])
                chain[i] <= (chain[i] >> 1) | ({63'd0, chain_d[i]} << (LENS[i] - 1));
        end
    end

    // Observe outputs mid-cycle.
    always @(negedge CK) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (chain_en[i]) shifts[i]++;
            if (out_valid[i]) begin
                if (nout[i] < 8) outb[i][nout[i]] = out_data[i];
                nout[i]++;
                last_ov[i] = cyc;
            end
            if (done[i]) begin
                ndone[i]++;
                done_cyc[i] = cyc;
            end
            if (in_valid[i] && in_ready[i]) nhs[i]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prefill(input int d, input logic [63:0] v);
        pre_val[d] = v;
        pre_req[d] = 1'b1;
        @(posedge CK); #1;
        pre_req[d] = 1'b0;
    endtask

    task automatic wait_ready(input int d, input bit glitch);
        int t = 0;
        @(negedge CK);
        while (!in_ready[d] && t < 60) begin
            start[d] = glitch & chain_en[d];
            @(negedge CK);
            t++;
        end
        start[d] = 1'b0;
        if (t >= 60) chk("ready_timeout", 64'(t), 64'd0);
    endtask

    task automatic do_load(input int d, input logic [63:0] pre, input int gap,
                           input bit glitch, input bit extra);
        int len    = LENS[d];
        int nbytes = (len + 7) / 8;
        int t      = 0;
        logic [63:0] mask = (64'd1 << len) - 64'd1;
        logic [63:0] exp_chain = 64'd0;
        prefill(d, pre & mask);
        shifts[d] = 0; nout[d] = 0; ndone[d] = 0; nhs[d] = 0;
        last_ov[d] = 0; done_cyc[d] = 0;
        start[d] = 1'b1;
        @(posedge CK); #1;
        start[d] = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            in_data[d] = tb_bytes[k];
            exp_chain  = exp_chain | ({56'd0, tb_bytes[k]} << (8 * k));
            if (k > 0 && gap > 0) begin
                in_valid[d] = 1'b0;
                wait_ready(d, glitch);
                for (int g = 0; g < gap; g++) begin
                    chk("gap_in_ready", 64'(in_ready[d]), 64'd1);
                    chk("gap_chain_en", 64'(chain_en[d]), 64'd0);
                    @(posedge CK); #1;
                    if (g < gap - 1) @(negedge CK);
                end
                in_valid[d] = 1'b1;
                wait_ready(d, glitch);
            end else begin
                in_valid[d] = 1'b1;
                wait_ready(d, glitch);
            end
            @(posedge CK); #1;
        end
        in_valid[d] = extra;
        while (ndone[d] == 0 && t < 60) begin
            @(negedge CK);
            start[d] = glitch & out_valid[d] & ~busy[d];
            t++;
        end
        start[d] = 1'b0;
        repeat (4) @(negedge CK);
        in_valid[d] = 1'b0;
        exp_chain = exp_chain & mask;
        chk("done_timeout", 64'(t >= 60), 64'd0);
        chk("shift_count", 64'(shifts[d]), 64'(len));
        chk("bytes_accepted", 64'(nhs[d]), 64'(nbytes));
        chk("out_count", 64'(nout[d]), 64'(nbytes));
        for (int k = 0; k < nbytes && k < nout[d]; k++)
            chk("out_byte", {56'd0, outb[d][k]}, 64'(8'(((pre & mask) >> (8 * k)))));
        chk("chain_contents", chain[d], exp_chain);
        chk("done_count", 64'(ndone[d]), 64'd1);
        chk("done_latency", 64'(done_cyc[d]), 64'(last_ov[d] + 1));
    endtask

    initial begin
        int t;
        RST = 1'b1;
        start = 3'd0;
        in_valid = 3'd0;
        pre_req = 3'd0;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = 8'd0;
            pre_val[i] = 64'd0;
            chain[i] = 64'd0;
            shifts[i] = 0; nout[i] = 0; ndone[i] = 0; nhs[i] = 0;
            last_ov[i] = 0; done_cyc[i] = 0;
        end
        repeat (3) @(negedge CK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(in_ready[i]), 64'd0);
            chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
            chk("rst_chain_en", 64'(chain_en[i]), 64'd0);
            chk("rst_chain_d", 64'(chain_d[i]), 64'd0);
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_out_data", {56'd0, out_data[i]}, 64'd0);
        end
        @(posedge CK); #1;
        RST = 1'b0;

        tb_bytes[0] = 8'h3C; tb_bytes[1] = 8'hF0;
        do_load(0, 64'hA55A, 0, 1'b0, 1'b0);
        do_load(0, 64'hA55A, 5, 1'b0, 1'b0);

        tb_bytes[0] = 8'h21; tb_bytes[1] = 8'hAB;
        do_load(1, 64'hFFF, 0, 1'b0, 1'b1);

        tb_bytes[0] = 8'h5E; tb_bytes[1] = 8'h91;
        do_load(0, 64'h1234, 2, 1'b1, 1'b0);

        tb_bytes[0] = 8'h01;
        do_load(2, 64'h0, 0, 1'b0, 1'b0);
        do_load(2, 64'h1, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int d = int'($urandom_range(0, 2));
            for (int k = 0; k < 8; k++) tb_bytes[k] = 8'($urandom);
            do_load(d, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a load, then a full reload from the partial chain.
        prefill(0, {48'd0, 16'($urandom)});
        shifts[0] = 0;
        start[0] = 1'b1;
        @(posedge CK); #1;
        start[0] = 1'b0;
        in_data[0] = 8'($urandom);
        in_valid[0] = 1'b1;
        t = 0;
        while (shifts[0] < 5 && t < 40) begin
            @(negedge CK); #1;
            t++;
        end
        chk("mid_rst_timeout", 64'(t >= 40), 64'd0);
        RST = 1'b1;
        #1;
        chk("mid_rst_chain_en", 64'(chain_en[0]), 64'd0);
        chk("mid_rst_busy", 64'(busy[0]), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
        in_valid[0] = 1'b0;
        @(posedge CK); #1;
        RST = 1'b0;
        tb_bytes[0] = 8'($urandom); tb_bytes[1] = 8'($urandom);
        do_load(0, chain[0], 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
